lamp_command_sequencer: RTL

//   Command front-end for the lamp mode/state FSM. Conditions the raw push

---
 rtl/lamp_command_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lamp_command_sequencer.sv
`default_nettype none
// ============================================================================
// lamp_command_sequencer : conditions button/presence/dark inputs and issues
//                          single-cycle command pulses to the lamp FSM
// Revision 1.0
// ============================================================================
module lamp_command_sequencer #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 16,
  parameter int HOLD_OFF_CYCLES   = 32,
  parameter int GUARD_CYCLES      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic presence,
  input  logic dark,
  input  logic lamp_on,
  input  logic manual_mode,
  output logic cmd_mode,
  output logic cmd_toggle,
  output logic cmd_off_auto,
  output logic cmd_on_auto
);

  localparam int c_db_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_press_w = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int c_timer_w = $clog2(HOLD_OFF_CYCLES + 1);
  localparam int c_guard_w = $clog2(GUARD_CYCLES + 1);

  localparam logic [c_db_w-1:0]    c_db_last   = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_press_w-1:0] c_long_last = c_press_w'(LONG_PRESS_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_hold      = c_timer_w'(HOLD_OFF_CYCLES);
  localparam logic [c_guard_w-1:0] c_guard     = c_guard_w'(GUARD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESSED   = 2'd1,
    S_LONG_WAIT = 2'd2
  } press_state_t;

  logic [1:0]           r_btn_sync;
  logic [1:0]           r_pres_sync;
  logic [1:0]           r_dark_sync;
  logic                 w_btn_s;
  logic                 w_pres_s;
  logic                 w_dark_s;
  logic [c_db_w-1:0]    r_db_cnt;
  logic                 r_btn_db;
  press_state_t         r_state;
  press_state_t         w_state_nxt;
  logic [c_press_w-1:0] r_press_cnt;
  logic [c_press_w-1:0] w_press_cnt_nxt;
  logic                 w_long_evt;
  logic                 w_short_evt;
  logic [c_timer_w-1:0] r_timer;
  logic [c_guard_w-1:0] r_guard;
  logic                 r_pend_tog;
  logic                 w_mode_cand;
  logic                 w_tog_cand;
  logic                 w_auto_ok;
  logic                 w_on_req;
  logic                 w_off_req;
  logic                 w_sel_mode;
  logic                 w_sel_tog;
  logic                 w_sel_off;
  logic                 w_sel_on;
  logic                 w_any;
  logic                 w_hold_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_sync  <= '0;
      r_pres_sync <= '0;
      r_dark_sync <= '0;
    end else begin
      r_btn_sync  <= {r_btn_sync[0], btn_raw};
      r_pres_sync <= {r_pres_sync[0], presence};
      r_dark_sync <= {r_dark_sync[0], dark};
    end
  end

  assign w_btn_s  = r_btn_sync[1];
  assign w_pres_s = r_pres_sync[1];
  assign w_dark_s = r_dark_sync[1];

  // Debounced level flips only after an unbroken run of disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_btn_db <= 1'b0;
    end else if (w_btn_s == r_btn_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == c_db_last) begin
      r_db_cnt <= '0;
      r_btn_db <= ~r_btn_db;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_press_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_press_cnt <= w_press_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_press_cnt_nxt = r_press_cnt;
    w_long_evt      = 1'b0;
    w_short_evt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_btn_db) begin
          w_state_nxt     = S_PRESSED;
          w_press_cnt_nxt = c_press_w'(1);
        end
      end
      S_PRESSED: begin
        if (!r_btn_db) begin
          w_short_evt = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_press_cnt_nxt = r_press_cnt + 1'b1;
          if (r_press_cnt == c_long_last) begin
            w_long_evt  = 1'b1;
            w_state_nxt = S_LONG_WAIT;
          end
        end
      end
      S_LONG_WAIT: begin
        if (!r_btn_db) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Button commands ignore the guard; auto requests are recomputed every cycle.
  assign w_mode_cand = w_long_evt;
  assign w_tog_cand  = (w_short_evt & manual_mode) | r_pend_tog;
  assign w_auto_ok   = ~manual_mode & (r_guard == '0);
  assign w_on_req    = w_auto_ok & w_pres_s & w_dark_s & ~lamp_on;
  assign w_off_req   = w_auto_ok & lamp_on & ~w_pres_s & (r_timer == '0);

  assign w_sel_mode  = w_mode_cand;
  assign w_sel_tog   = w_tog_cand & ~w_mode_cand;
  assign w_sel_off   = w_off_req & ~w_mode_cand & ~w_tog_cand;
  assign w_sel_on    = w_on_req & ~w_off_req & ~w_mode_cand & ~w_tog_cand;
  assign w_any       = w_mode_cand | w_tog_cand | w_off_req | w_on_req;
  assign w_hold_load = ~lamp_on | manual_mode | w_pres_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_mode     <= 1'b0;
      cmd_toggle   <= 1'b0;
      cmd_off_auto <= 1'b0;
      cmd_on_auto  <= 1'b0;
      r_pend_tog   <= 1'b0;
      r_timer      <= c_hold;
      r_guard      <= '0;
    end else begin
      cmd_mode     <= w_sel_mode;
      cmd_toggle   <= w_sel_tog;
      cmd_off_auto <= w_sel_off;
      cmd_on_auto  <= w_sel_on;
      r_pend_tog   <= w_mode_cand & w_tog_cand;

      if (w_hold_load) begin
        r_timer <= c_hold;
      end else if (r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end

      if (w_any) begin
        r_guard <= c_guard;
      end else if (r_guard != '0) begin
        r_guard <= r_guard - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
